// File: rtl/tetris_pkg.sv
// Shared constants and the gravity-period helper for the Tetris input front end.
package tetris_pkg;

    localparam int unsigned NUM_KEYS = 7;
    localparam int unsigned LEVEL_W  = 4;

    localparam int unsigned KEY_UP    = 0;
    localparam int unsigned KEY_DOWN  = 1;
    localparam int unsigned KEY_LEFT  = 2;
    localparam int unsigned KEY_RIGHT = 3;
    localparam int unsigned KEY_SPACE = 4;
    localparam int unsigned KEY_ENTER = 5;
    localparam int unsigned KEY_EXC   = 6;

    // max(base - level*step, pmin) without letting the subtraction wrap
    function automatic logic [31:0] grav_period(
        input logic [LEVEL_W-1:0] level,
        input logic [31:0]        base,
        input logic [31:0]        step,
        input logic [31:0]        pmin
    );
        logic [31:0] sub;
        sub = 32'(level) * step;
        if (sub >= base || (base - sub) < pmin) begin
            return pmin;
        end
        return base - sub;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One button: 2-flop synchroniser, hold-time debouncer and registered rising-edge pulse.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    output logic stable,
    output logic pulse
);

    localparam int unsigned     CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          prev_q, prev_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = btn;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        prev_d  = stable_q;
        pulse_d = stable_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign pulse  = pulse_q;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Tetris input front end: debounced key pulses, L/R cancel, gravity tick.
// Define AUTOREPEAT_EN to make down/left/right repeat while held.
module tetris_input_ctrl
    import tetris_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1_000_000,
    parameter int unsigned REP_DELAY  = 20_000_000,
    parameter int unsigned REP_RATE   = 5_000_000,
    parameter int unsigned GRAV_BASE  = 50_000_000,
    parameter int unsigned GRAV_STEP  = 4_000_000,
    parameter int unsigned GRAV_MIN   = 5_000_000
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_space,
    input  logic         btn_enter,
    input  logic         btn_exc,
    input  logic         pause,
    input  logic [3:0]   level,
    output logic         up,
    output logic         down,
    output logic         left,
    output logic         right,
    output logic         space,
    output logic         enter,
    output logic         exc,
    output logic         drop
);

    logic [NUM_KEYS-1:0] raw, stable, pulse, key_out;
    logic [NUM_KEYS-1:0] out_q, out_d;
    logic                lr_both;
    logic                stable_unused;
    logic [31:0]         period;
    logic [31:0]         grav_cnt_q, grav_cnt_d;
    logic                drop_q, drop_d;

    assign raw[KEY_UP]    = btn_up;
    assign raw[KEY_DOWN]  = btn_down;
    assign raw[KEY_LEFT]  = btn_left;
    assign raw[KEY_RIGHT] = btn_right;
    assign raw[KEY_SPACE] = btn_space;
    assign raw[KEY_ENTER] = btn_enter;
    assign raw[KEY_EXC]   = btn_exc;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk    (clk),
            .rstn   (rstn),
            .btn    (raw[i]),
            .stable (stable[i]),
            .pulse  (pulse[i])
        );
    end

    assign lr_both       = stable[KEY_LEFT] & stable[KEY_RIGHT];
    assign stable_unused = ^stable;

`ifdef AUTOREPEAT_EN
    localparam int unsigned NUM_REP = 3;
    localparam int unsigned REP_IDX [NUM_REP] = '{KEY_DOWN, KEY_LEFT, KEY_RIGHT};
    localparam logic [31:0] REP_FIRST_LAST = 32'(REP_DELAY - 1);
    localparam logic [31:0] REP_NEXT_LAST  = 32'(REP_RATE - 1);

    logic [31:0]         rep_cnt_q [NUM_REP];
    logic [31:0]         rep_cnt_d [NUM_REP];
    logic [NUM_REP-1:0]  rep_phase_q, rep_phase_d;
    logic [NUM_KEYS-1:0] rep_fire;

    // Phase 0 waits REP_DELAY after the press pulse, phase 1 repeats every REP_RATE.
    always_comb begin
        rep_fire = '0;
        for (int unsigned j = 0; j < NUM_REP; j++) begin
            rep_cnt_d[j]   = rep_cnt_q[j] + 32'd1;
            rep_phase_d[j] = rep_phase_q[j];
            if (!stable[REP_IDX[j]] || pulse[REP_IDX[j]] ||
                (lr_both && REP_IDX[j] != KEY_DOWN)) begin
                rep_cnt_d[j]   = '0;
                rep_phase_d[j] = 1'b0;
            end else if (rep_cnt_q[j] == (rep_phase_q[j] ? REP_NEXT_LAST : REP_FIRST_LAST)) begin
                rep_cnt_d[j]           = '0;
                rep_phase_d[j]         = 1'b1;
                rep_fire[REP_IDX[j]]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned j = 0; j < NUM_REP; j++) begin
                rep_cnt_q[j] <= '0;
            end
            rep_phase_q <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_REP; j++) begin
                rep_cnt_q[j] <= rep_cnt_d[j];
            end
            rep_phase_q <= rep_phase_d;
        end
    end
`endif

    always_comb begin
        key_out = pulse;
        if (lr_both) begin
            key_out[KEY_LEFT]  = 1'b0;
            key_out[KEY_RIGHT] = 1'b0;
        end
`ifdef AUTOREPEAT_EN
        key_out = key_out | rep_fire;
`endif
        out_d = key_out;
    end

    assign period = grav_period(level, 32'(GRAV_BASE), 32'(GRAV_STEP), 32'(GRAV_MIN));

    // space/enter restart the fall timer and win over a coincident tick
    always_comb begin
        grav_cnt_d = grav_cnt_q;
        drop_d     = 1'b0;
        if (key_out[KEY_SPACE] || key_out[KEY_ENTER]) begin
            grav_cnt_d = '0;
        end else if (!pause) begin
            if (grav_cnt_q >= period - 32'd1) begin
                grav_cnt_d = '0;
                drop_d     = 1'b1;
            end else begin
                grav_cnt_d = grav_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q      <= '0;
            drop_q     <= 1'b0;
            grav_cnt_q <= '0;
        end else begin
            out_q      <= out_d;
            drop_q     <= drop_d;
            grav_cnt_q <= grav_cnt_d;
        end
    end

    assign up    = out_q[KEY_UP];
    assign down  = out_q[KEY_DOWN];
    assign left  = out_q[KEY_LEFT];
    assign right = out_q[KEY_RIGHT];
    assign space = out_q[KEY_SPACE];
    assign enter = out_q[KEY_ENTER];
    assign exc   = out_q[KEY_EXC];
    assign drop  = drop_q;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl: expected output events are queued with their
// cycle numbers and matched against every output pulse the DUT produces.
module tb_tetris_input_ctrl;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RR  = 5;
    localparam int GB  = 40;
    localparam int GS  = 4;
    localparam int GM  = 8;

    // event ids: key index (up,down,left,right,space,enter,exc) or 7 for drop
    localparam int ID_UP = 0, ID_LEFT = 2, ID_SPACE = 4, ID_EXC = 6, ID_DROP = 7;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
    logic btn_space = 0, btn_enter = 0, btn_exc = 0;
    logic pause = 1'b1;
    logic [3:0] level = '0;
    logic up, down, left, right, space, enter, exc, drop;
    logic [7:0] outs;

    tetris_input_ctrl #(
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RD),
        .REP_RATE   (RR),
        .GRAV_BASE  (GB),
        .GRAV_STEP  (GS),
        .GRAV_MIN   (GM)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_space (btn_space),
        .btn_enter (btn_enter),
        .btn_exc   (btn_exc),
        .pause     (pause),
        .level     (level),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .space     (space),
        .enter     (enter),
        .exc       (exc),
        .drop      (drop)
    );

    assign outs = {drop, exc, enter, space, right, left, down, up};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int id;
        int c;
    } ev_t;

    ev_t expq[$];
    int  checks = 0;
    int  failures = 0;
    int  t;

    task automatic expect_ev(input int id, input int c);
        ev_t e;
        e.id = id;
        e.c  = c;
        expq.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick(1);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            for (int i = 0; i < 8; i++) begin
                if (outs[i]) begin
                    ev_t e;
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                    end else begin
                        e.id = -1;
                        e.c  = -1;
                    end
                    checks++;
                    assert (i === e.id && cyc === e.c)
                    else begin
                        failures++;
                        $error("FAIL event: got id=%0d cyc=%0d, want id=%0d cyc=%0d", i, cyc, e.id, e.c);
                    end
                end
            end
        end
    end

    task automatic end_phase(input string name);
        checks++;
        assert (expq.size() === 0)
        else begin
            failures++;
            $error("FAIL %s: pending expected events=%0d, want 0", name, expq.size());
        end
        expq.delete();
    endtask

    // Reset with the given level/pause; returns the cycle of the last edge before release.
    task automatic do_reset(input logic [3:0] lvl, input logic pse, input logic exc_held,
                            output int t_rel);
        rstn = 1'b0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        btn_space = 0; btn_enter = 0; btn_exc = exc_held;
        level = lvl;
        pause = pse;
        expq.delete();
        #1;
        checks++;
        assert (outs === 8'h00)
        else begin
            failures++;
            $error("FAIL reset_state: outs=%b want=%b", outs, 8'h00);
        end
        tick(2);
        rstn = 1'b1;
        t_rel = cyc;
    endtask

    initial begin
        // 1: bouncy left press, clean rise driven at t+10
        do_reset(4'd0, 1'b1, 1'b0, t);
        tick_to(t + 2);  btn_left = 1;
        tick_to(t + 3);  btn_left = 0;
        tick_to(t + 5);  btn_left = 1;
        tick_to(t + 6);  btn_left = 0;
        tick_to(t + 8);  btn_left = 1;
        tick_to(t + 9);  btn_left = 0;
        expect_ev(ID_LEFT, t + 10 + 1 + DEB + 3);
`ifdef AUTOREPEAT_EN
        for (int j = 0; j < 5; j++) expect_ev(ID_LEFT, t + 18 + RD + j * RR);
`endif
        tick_to(t + 10); btn_left = 1;
        tick_to(t + 55); btn_left = 0;
        tick_to(t + 75);
        end_phase("left_press");

        // 2: 3-cycle glitch on up, then a 10-cycle hold
        do_reset(4'd0, 1'b1, 1'b0, t);
        tick_to(t + 2);  btn_up = 1;
        tick_to(t + 5);  btn_up = 0;
        expect_ev(ID_UP, t + 20 + 1 + DEB + 3);
        tick_to(t + 20); btn_up = 1;
        tick_to(t + 30); btn_up = 0;
        tick_to(t + 50);
        end_phase("up_glitch_hold");

        // 3: gravity periods at several levels (15 checks the floor without underflow)
        do_reset(4'd0, 1'b0, 1'b0, t);
        for (int j = 1; j <= 3; j++) expect_ev(ID_DROP, t + j * 40);
        tick_to(t + 125);
        end_phase("grav_l0");

        do_reset(4'd9, 1'b0, 1'b0, t);
        for (int j = 1; j <= 4; j++) expect_ev(ID_DROP, t + j * 8);
        tick_to(t + 35);
        end_phase("grav_l9");

        do_reset(4'd15, 1'b0, 1'b0, t);
        for (int j = 1; j <= 2; j++) expect_ev(ID_DROP, t + j * 8);
        tick_to(t + 20);
        end_phase("grav_l15");

        do_reset(4'd2, 1'b0, 1'b0, t);
        for (int j = 1; j <= 2; j++) expect_ev(ID_DROP, t + j * 32);
        tick_to(t + 70);
        end_phase("grav_l2");

        // level raised at count 20: the overrun counter ticks at the next compare
        do_reset(4'd0, 1'b0, 1'b0, t);
        expect_ev(ID_DROP, t + 21);
        expect_ev(ID_DROP, t + 29);
        tick_to(t + 20); level = 4'd9;
        tick_to(t + 32);
        end_phase("grav_level_change");

        // 4: pause held at count 25; pause first sampled low at edge t+126
        do_reset(4'd0, 1'b0, 1'b0, t);
        expect_ev(ID_DROP, t + 125 + GB - 25);
        expect_ev(ID_DROP, t + 125 + GB - 25 + GB);
        tick_to(t + 25);  pause = 1'b1;
        tick_to(t + 125); pause = 1'b0;
        tick_to(t + 185);
        end_phase("pause");

        // 5: space pulse lands on the cycle the first tick would
        do_reset(4'd0, 1'b0, 1'b0, t);
        expect_ev(ID_SPACE, t + 40);
        expect_ev(ID_DROP, t + 80);
        tick_to(t + 32); btn_space = 1;
        tick_to(t + 45); btn_space = 0;
        tick_to(t + 85);
        end_phase("space_vs_tick");

        // 6a: left and right held together cancel each other
        do_reset(4'd0, 1'b1, 1'b0, t);
        tick_to(t + 2);  btn_left = 1; btn_right = 1;
        tick_to(t + 40); btn_left = 0; btn_right = 0;
        tick_to(t + 60);
        end_phase("lr_cancel");

        // 6b: exc held through reset release pulses once
        do_reset(4'd0, 1'b1, 1'b1, t);
        expect_ev(ID_EXC, t + 1 + DEB + 3);
        tick_to(t + 15); btn_exc = 0;
        tick_to(t + 30);
        end_phase("held_through_reset");

        // 6c: reset asserted while drop is high clears outputs immediately
        do_reset(4'd0, 1'b0, 1'b0, t);
        tick_to(t + 40);
        checks++;
        assert (drop === 1'b1)
        else begin
            failures++;
            $error("FAIL drop_before_reset: drop=%b want=1", drop);
        end
        rstn = 1'b0;
        #1;
        checks++;
        assert (outs === 8'h00)
        else begin
            failures++;
            $error("FAIL async_reset: outs=%b want=%b", outs, 8'h00);
        end
        end_phase("async_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
